// File: rtl/elevator_pkg.sv
// Shared floor/engine codes, scheduler state encoding and floor-mask helpers
// for the elevator call scheduler.
package elevator_pkg;

    localparam int unsigned FLOOR_COUNT = 3;

    localparam logic [1:0] FLOOR1     = 2'b00;
    localparam logic [1:0] FLOOR2     = 2'b01;
    localparam logic [1:0] FLOOR3     = 2'b10;
    localparam logic [1:0] FLOOR_NONE = 2'b11;

    localparam logic [1:0] ENG_STOP = 2'b00;
    localparam logic [1:0] ENG_UP   = 2'b01;
    localparam logic [1:0] ENG_DOWN = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StMove,
        StDoorOpen,
        StDoorClose,
        StFault
    } sched_state_e;

    function automatic logic [FLOOR_COUNT-1:0] floor_onehot(input logic [1:0] floor);
        logic [FLOOR_COUNT-1:0] mask;
        case (floor)
            FLOOR1:  mask = 3'b001;
            FLOOR2:  mask = 3'b010;
            FLOOR3:  mask = 3'b100;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

    function automatic logic [FLOOR_COUNT-1:0] floors_above(input logic [1:0] floor);
        logic [FLOOR_COUNT-1:0] mask;
        case (floor)
            FLOOR1:  mask = 3'b110;
            FLOOR2:  mask = 3'b100;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

    function automatic logic [FLOOR_COUNT-1:0] floors_below(input logic [1:0] floor);
        logic [FLOOR_COUNT-1:0] mask;
        case (floor)
            FLOOR2:  mask = 3'b001;
            FLOOR3:  mask = 3'b011;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/elevator_door_timer.sv
// Door dwell timer: load/restart sets DOOR_CYCLES-1, counts down while enabled,
// o_done is high once the count has run out.
module elevator_door_timer
    import elevator_pkg::*;
#(
    parameter int unsigned DOOR_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);

    localparam int unsigned CW = $clog2(DOOR_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = CW'(DOOR_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler for a 3-floor car: latches calls, drives engine and door request.
// Optional travel watchdog enabled by defining SCHED_WATCHDOG_EN.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned N_FLOORS       = 3,
    parameter int unsigned DOOR_CYCLES    = 8,
    parameter int unsigned TRAVEL_TIMEOUT = 64
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [N_FLOORS-1:0] i_call_req,
    input  logic [1:0]          i_cur_floor,
    input  logic                i_door_closed,
    output logic [1:0]          o_engine,
    output logic                o_door_open,
    output logic [N_FLOORS-1:0] o_pending,
    output logic                o_dir_up,
    output logic                o_fault
);

    if ((N_FLOORS != 3) || (DOOR_CYCLES < 2) || (TRAVEL_TIMEOUT < 2)) begin : g_bad_params
        $error("elevator_call_scheduler: unsupported parameter values");
    end

    sched_state_e        r_state;
    logic [1:0]          r_engine;
    logic                r_door_open;
    logic [N_FLOORS-1:0] r_pending;
    logic                r_dir_up;
    logic [1:0]          r_prev_floor;

    logic                w_floor_valid;
    logic [N_FLOORS-1:0] w_here;
    logic                w_up_ahead;
    logic                w_down_ahead;
    logic                w_call_here;
    logic                w_call_else;
    logic                w_floor_changed;
    logic                w_dir_next;
    logic [1:0]          w_eng_next;
    logic                w_restart;
    logic                w_open_idle;
    logic                w_open_move;
    logic                w_timer_load;
    logic                w_timer_en;
    logic                w_timer_done;
    logic [N_FLOORS-1:0] w_clear;
    logic [N_FLOORS-1:0] w_req_masked;
    logic                w_wd_trip;

    always_comb begin
        w_floor_valid   = (i_cur_floor != FLOOR_NONE);
        w_here          = floor_onehot(i_cur_floor);
        w_up_ahead      = |(r_pending & floors_above(i_cur_floor));
        w_down_ahead    = |(r_pending & floors_below(i_cur_floor));
        w_call_here     = |(r_pending & w_here);
        w_call_else     = w_up_ahead | w_down_ahead;
        w_floor_changed = w_floor_valid && (i_cur_floor != r_prev_floor);

        // SCAN: keep the sweep while calls lie ahead, reverse only when all are behind
        if (i_cur_floor == FLOOR1) begin
            w_dir_next = 1'b1;
        end else if (i_cur_floor == FLOOR3) begin
            w_dir_next = 1'b0;
        end else if (r_dir_up) begin
            w_dir_next = w_up_ahead || !w_down_ahead;
        end else begin
            w_dir_next = w_up_ahead && !w_down_ahead;
        end

        if (!w_floor_valid) begin
            w_eng_next = ENG_STOP;
        end else if (w_dir_next) begin
            w_eng_next = (i_cur_floor == FLOOR3) ? ENG_STOP : ENG_UP;
        end else begin
            w_eng_next = (i_cur_floor == FLOOR1) ? ENG_STOP : ENG_DOWN;
        end

        w_restart    = (r_state == StDoorOpen) && w_floor_valid && |(i_call_req & w_here);
        w_open_idle  = (r_state == StIdle) && w_floor_valid && w_call_here;
        w_open_move  = (r_state == StMove) && w_floor_changed && w_call_here && !w_wd_trip;
        w_timer_load = w_open_idle || w_open_move || w_restart;
        w_timer_en   = (r_state == StDoorOpen) && w_floor_valid;
        w_clear      = (w_open_idle || w_open_move) ? w_here : '0;
        w_req_masked = w_restart ? (i_call_req & ~w_here) : i_call_req;
    end

    elevator_door_timer #(
        .DOOR_CYCLES (DOOR_CYCLES)
    ) u_door_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_timer_load),
        .i_en    (w_timer_en),
        .o_done  (w_timer_done)
    );

`ifdef SCHED_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TRAVEL_TIMEOUT);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_fault;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wd_cnt <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_fault <= r_fault | w_wd_trip;
            if ((r_state != StMove) || w_floor_changed) begin
                r_wd_cnt <= '0;
            end else if (!w_wd_trip) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
        end
    end

    assign w_wd_trip = (r_state == StMove) && !w_floor_changed &&
                       (r_wd_cnt == WD_W'(TRAVEL_TIMEOUT - 1));
    assign o_fault   = r_fault;
`else
    assign w_wd_trip = 1'b0;
    assign o_fault   = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_engine     <= ENG_STOP;
            r_door_open  <= 1'b0;
            r_pending    <= '0;
            r_dir_up     <= 1'b1;
            r_prev_floor <= i_cur_floor;
        end else begin
            r_pending <= (r_pending | w_req_masked) & ~w_clear;
            if (w_floor_valid) begin
                r_prev_floor <= i_cur_floor;
            end

            if (w_wd_trip) begin
                r_state  <= StFault;
                r_engine <= ENG_STOP;
            end else if (!w_floor_valid) begin
                // Position unknown: stop and hold everything else
                r_engine <= ENG_STOP;
            end else begin
                case (r_state)
                    StIdle: begin
                        r_dir_up <= w_dir_next;
                        r_engine <= ENG_STOP;
                        if (w_call_here) begin
                            r_state     <= StDoorOpen;
                            r_door_open <= 1'b1;
                        end else if (w_call_else && i_door_closed) begin
                            r_state  <= StMove;
                            r_engine <= w_eng_next;
                        end
                    end
                    StMove: begin
                        r_dir_up <= w_dir_next;
                        if (w_open_move) begin
                            r_state     <= StDoorOpen;
                            r_door_open <= 1'b1;
                            r_engine    <= ENG_STOP;
                        end else if (!i_door_closed) begin
                            r_engine <= ENG_STOP;
                        end else if (!w_call_else) begin
                            r_state  <= StIdle;
                            r_engine <= ENG_STOP;
                        end else begin
                            r_engine <= w_eng_next;
                        end
                    end
                    StDoorOpen: begin
                        r_dir_up <= w_dir_next;
                        r_engine <= ENG_STOP;
                        if (!w_restart && w_timer_done) begin
                            r_state     <= StDoorClose;
                            r_door_open <= 1'b0;
                        end
                    end
                    StDoorClose: begin
                        r_dir_up <= w_dir_next;
                        r_engine <= ENG_STOP;
                        if (i_door_closed) begin
                            if (w_call_else) begin
                                r_state  <= StMove;
                                r_engine <= w_eng_next;
                            end else begin
                                r_state <= StIdle;
                            end
                        end
                    end
                    default: begin
                        r_engine <= ENG_STOP;
                    end
                endcase
            end
        end
    end

    assign o_engine    = r_engine;
    assign o_door_open = r_door_open;
    assign o_pending   = r_pending;
    assign o_dir_up    = r_dir_up;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed, table-driven bench for elevator_call_scheduler plus hand sequences for
// door-timer restart, door-open hold in IDLE and the travel watchdog.
module tb_elevator_call_scheduler;

    logic       clk;
    logic       rst;
    logic [2:0] call_req;
    logic [1:0] cur_floor;
    logic       door_closed;
    logic [1:0] engine;
    logic       door_open;
    logic [2:0] pending;
    logic       dir_up;
    logic       fault;

    int n_tests;
    int n_fail;

    typedef struct {
        logic       rst;
        logic [2:0] call;
        logic [1:0] floor;
        logic       dc;
        logic [1:0] eng;
        logic       door;
        logic [2:0] pend;
        logic       dir;
    } vec_t;

    vec_t vecs[$];

    elevator_call_scheduler #(
        .N_FLOORS       (3),
        .DOOR_CYCLES    (8),
        .TRAVEL_TIMEOUT (64)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_call_req    (call_req),
        .i_cur_floor   (cur_floor),
        .i_door_closed (door_closed),
        .o_engine      (engine),
        .o_door_open   (door_open),
        .o_pending     (pending),
        .o_dir_up      (dir_up),
        .o_fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input logic r, input logic [2:0] c, input logic [1:0] f,
                           input logic d, input logic [1:0] e, input logic o,
                           input logic [2:0] p, input logic u);
        vec_t v;
        v.rst = r; v.call = c; v.floor = f; v.dc = d;
        v.eng = e; v.door = o; v.pend = p; v.dir = u;
        vecs.push_back(v);
    endtask

    // Drive at the falling edge, let one rising edge pass, sample 1ns later
    task automatic apply(input logic r, input logic [2:0] c, input logic [1:0] f, input logic d);
        @(negedge clk);
        rst = r; call_req = c; cur_floor = f; door_closed = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] e, input logic o,
                         input logic [2:0] p, input logic u, input logic flt);
        n_tests++;
        if ({engine, door_open, pending, dir_up, fault} !== {e, o, p, u, flt}) begin
            n_fail++;
            $display("FAIL %s: got eng=%b door=%b pend=%b dir=%b fault=%b, want eng=%b door=%b pend=%b dir=%b fault=%b",
                     name, engine, door_open, pending, dir_up, fault, e, o, p, u, flt);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; call_req = 3'b000; cur_floor = 2'b00; door_closed = 1'b1;

        // rst call floor dc | eng door pend dir
        add_vec(1, 3'b111, 2'b00, 1, 2'b00, 0, 3'b000, 1);
        add_vec(0, 3'b000, 2'b00, 1, 2'b00, 0, 3'b000, 1);
        add_vec(0, 3'b100, 2'b00, 1, 2'b00, 0, 3'b100, 1);
        add_vec(0, 3'b000, 2'b00, 1, 2'b01, 0, 3'b100, 1);
        add_vec(0, 3'b000, 2'b01, 1, 2'b01, 0, 3'b100, 1);
        add_vec(0, 3'b001, 2'b01, 1, 2'b01, 0, 3'b101, 1);
        add_vec(0, 3'b000, 2'b01, 1, 2'b01, 0, 3'b101, 1);
        add_vec(0, 3'b000, 2'b10, 1, 2'b00, 1, 3'b001, 0);
        repeat (7) add_vec(0, 3'b000, 2'b10, 1, 2'b00, 1, 3'b001, 0);
        add_vec(0, 3'b000, 2'b10, 1, 2'b00, 0, 3'b001, 0);
        add_vec(0, 3'b000, 2'b10, 1, 2'b10, 0, 3'b001, 0);
        add_vec(0, 3'b000, 2'b10, 0, 2'b00, 0, 3'b001, 0);
        add_vec(0, 3'b000, 2'b10, 0, 2'b00, 0, 3'b001, 0);
        add_vec(0, 3'b000, 2'b10, 1, 2'b10, 0, 3'b001, 0);
        add_vec(0, 3'b000, 2'b01, 1, 2'b10, 0, 3'b001, 0);
        add_vec(0, 3'b010, 2'b11, 1, 2'b00, 0, 3'b011, 0);
        add_vec(0, 3'b000, 2'b01, 1, 2'b10, 0, 3'b011, 0);
        add_vec(0, 3'b000, 2'b00, 1, 2'b00, 1, 3'b010, 1);
        repeat (7) add_vec(0, 3'b000, 2'b00, 1, 2'b00, 1, 3'b010, 1);
        add_vec(0, 3'b000, 2'b00, 1, 2'b00, 0, 3'b010, 1);
        add_vec(0, 3'b000, 2'b00, 1, 2'b01, 0, 3'b010, 1);
        add_vec(0, 3'b000, 2'b01, 1, 2'b00, 1, 3'b000, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].call, vecs[i].floor, vecs[i].dc);
            check($sformatf("vec%0d", i), vecs[i].eng, vecs[i].door, vecs[i].pend,
                  vecs[i].dir, 1'b0);
        end

        // Door open at floor2 since the last vector; a hall call there on cycle 5 restarts it
        for (int i = 1; i <= 4; i++) begin
            apply(0, 3'b000, 2'b01, 1);
            check($sformatf("door_pre%0d", i), 2'b00, 1, 3'b000, 1, 1'b0);
        end
        apply(0, 3'b010, 2'b01, 1);
        check("door_restart_press", 2'b00, 1, 3'b000, 1, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            apply(0, 3'b000, 2'b01, 1);
            check($sformatf("door_hold%0d", i), 2'b00, 1, 3'b000, 1, 1'b0);
        end
        apply(0, 3'b000, 2'b01, 1);
        check("door_closing", 2'b00, 0, 3'b000, 1, 1'b0);
        apply(0, 3'b000, 2'b01, 1);
        check("back_to_idle", 2'b00, 0, 3'b000, 1, 1'b0);

        // IDLE must not start moving while the door is open
        apply(0, 3'b001, 2'b01, 0);
        check("idle_latch_door_open", 2'b00, 0, 3'b001, 1, 1'b0);
        apply(0, 3'b000, 2'b01, 0);
        check("idle_hold_door_open", 2'b00, 0, 3'b001, 0, 1'b0);
        apply(0, 3'b000, 2'b01, 1);
        check("idle_start_down", 2'b10, 0, 3'b001, 0, 1'b0);

`ifdef SCHED_WATCHDOG_EN
        begin
            int trip_at;
            trip_at = 0;
            for (int k = 1; k <= 100; k++) begin
                apply(0, 3'b000, 2'b01, 1);
                if (fault === 1'b1) begin
                    trip_at = k;
                    break;
                end
            end
            n_tests++;
            if (trip_at != 64) begin
                n_fail++;
                $display("FAIL wd_trip_cycle: got %0d, want 64", trip_at);
            end
            for (int k = 0; k < 5; k++) apply(0, 3'b010, 2'b00, 1);
            check("wd_fault_sticky", 2'b00, 0, 3'b011, 0, 1'b1);
        end
`else
        for (int k = 0; k < 80; k++) apply(0, 3'b000, 2'b01, 1);
        check("no_watchdog_keep_moving", 2'b10, 0, 3'b001, 0, 1'b0);
`endif

        apply(1, 3'b111, 2'b00, 1);
        check("final_reset", 2'b00, 0, 3'b000, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
